mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the EX stage; sits beside the ALU.
- Consumes the same rs/rt operands from the ID/EX register and executes MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers, which feed the EX result mux for MFHI/MFLO.
- Drives o_busy so hazard logic can stall the pipeline until the result is ready.

---
 rtl/mult_div_unit_pkg.sv | 19 +
 rtl/mult_div_unit_if.sv | 33 +++
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 tb/tb_mult_div_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Shared constants for the EX-stage multiply/divide unit:
//   operation codes, FSM state encoding and the divide-by-zero LO value.
package mult_div_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Operand/control bundle between the ID/EX register and the MDU.
//   master : pipeline side (drives start/op/operands/MTHI/MTLO, reads HI/LO/status)
//   slave  : MDU side
//   Signals: i_start, i_op, i_operand_a, i_operand_b, i_mthi, i_mtlo, i_wr_data,
//            o_hi, o_lo, o_busy, o_done, o_div_by_zero
interface mult_div_unit_if #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 2
);
    logic               i_start;
    logic [NB_OP-1:0]   i_op;
    logic [NB_DATA-1:0] i_operand_a;
    logic [NB_DATA-1:0] i_operand_b;
    logic               i_mthi;
    logic               i_mtlo;
    logic [NB_DATA-1:0] i_wr_data;
    logic [NB_DATA-1:0] o_hi;
    logic [NB_DATA-1:0] o_lo;
    logic               o_busy;
    logic               o_done;
    logic               o_div_by_zero;

    modport master (
        output i_start, i_op, i_operand_a, i_operand_b, i_mthi, i_mtlo, i_wr_data,
        input  o_hi, o_lo, o_busy, o_done, o_div_by_zero
    );

    modport slave (
        input  i_start, i_op, i_operand_a, i_operand_b, i_mthi, i_mtlo, i_wr_data,
        output o_hi, o_lo, o_busy, o_done, o_div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
//   One iteration per clock over a shared 64-bit working register, followed by a
//   sign-fix cycle that writes HI/LO.
//   Ports:
//     i_clk, i_rst : clock, asynchronous active-high reset
//     bus (slave)  : start/op/operands, MTHI/MTLO write, HI/LO, busy/done/div-by-zero
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; MTHI/MTLO writes accepted
//   ST_CALC | 32 shift-add / restoring-divide iterations (count 31..0)
//   ST_FIX  | apply sign correction, write HI/LO, pulse done
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 2,
    parameter int NB_CNT  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mult_div_unit_if.slave   bus
);
    localparam int NB_ACC = 2 * NB_DATA;

    state_t             state, state_nxt;
    logic [NB_CNT-1:0]  cnt;
    logic [NB_OP-1:0]   op_q;
    logic [NB_ACC-1:0]  acc;
    logic [NB_DATA-1:0] opnd;
    logic               res_neg, rem_neg, div0;
    logic [NB_DATA-1:0] hi_q, lo_q;
    logic               busy_q, done_q, dbz_q;

    logic               accept;
    logic               a_neg, b_neg;
    logic [NB_DATA-1:0] abs_a, abs_b;
    logic [NB_DATA-1:0] acc_hi, acc_lo;
    logic [NB_DATA:0]   mul_sum;
    logic [NB_ACC-1:0]  mul_nxt;
    logic [NB_DATA:0]   div_rem;
    logic               div_ge;
    logic [NB_DATA-1:0] div_diff;
    logic [NB_ACC-1:0]  div_nxt;
    logic [NB_ACC-1:0]  prod_fix;
    logic [NB_DATA-1:0] quo_fix, rem_fix;

    assign accept = (state == ST_IDLE) && bus.i_start;

    // i_op[0] clear selects the signed variants (MULT, DIV).
    assign a_neg = ~bus.i_op[0] & bus.i_operand_a[NB_DATA-1];
    assign b_neg = ~bus.i_op[0] & bus.i_operand_b[NB_DATA-1];
    assign abs_a = a_neg ? -bus.i_operand_a : bus.i_operand_a;
    assign abs_b = b_neg ? -bus.i_operand_b : bus.i_operand_b;

    assign acc_hi = acc[NB_ACC-1:NB_DATA];
    assign acc_lo = acc[NB_DATA-1:0];

    // Multiply: acc = {partial product, multiplier}; add multiplicand on lsb, shift right.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(NB_DATA+1){1'b0}});
    assign mul_nxt = {mul_sum, acc_lo[NB_DATA-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
    // The remainder is always below the divisor, so the difference fits NB_DATA bits.
    assign div_rem  = {acc_hi, acc_lo[NB_DATA-1]};
    assign div_ge   = div_rem >= {1'b0, opnd};
    assign div_diff = div_rem[NB_DATA-1:0] - opnd;
    assign div_nxt  = {(div_ge ? div_diff : div_rem[NB_DATA-1:0]), acc_lo[NB_DATA-2:0], div_ge};

    // With a zero divisor every trial subtract succeeds, leaving |a| as the remainder;
    // the dividend-sign fix then restores the original operand a in HI.
    assign prod_fix = res_neg ? -acc : acc;
    assign quo_fix  = div0 ? DIV0_LO : (res_neg ? -acc_lo : acc_lo);
    assign rem_fix  = rem_neg ? -acc_hi : acc_hi;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.i_start) state_nxt = ST_CALC;
            ST_CALC: if (cnt == '0)   state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt     <= '0;
            op_q    <= '0;
            acc     <= '0;
            opnd    <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            div0    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt != ST_IDLE);
            done_q <= (state == ST_FIX);
            dbz_q  <= (state == ST_FIX) && div0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.i_op;
                        cnt     <= NB_CNT'(NB_DATA - 1);
                        opnd    <= bus.i_op[1] ? abs_b : abs_a;
                        acc     <= {{NB_DATA{1'b0}}, (bus.i_op[1] ? abs_a : abs_b)};
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg & bus.i_op[1];
                        div0    <= bus.i_op[1] && (bus.i_operand_b == '0);
                    end else begin
                        if (bus.i_mthi) hi_q <= bus.i_wr_data;
                        if (bus.i_mtlo) lo_q <= bus.i_wr_data;
                    end
                end
                ST_CALC: begin
                    acc <= op_q[1] ? div_nxt : mul_nxt;
                    cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    if (op_q[1]) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[NB_ACC-1:NB_DATA];
                        lo_q <= prod_fix[NB_DATA-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_hi          = hi_q;
    assign bus.o_lo          = lo_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if #(.NB_DATA(32), .NB_OP(2)) bus ();

    mult_div_unit #(.NB_DATA(32), .NB_OP(2), .NB_CNT(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int errs   = 0;
    int checks = 0;
    logic run_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0, m_dbz = 1'b0, p_dz = 1'b0;
    int          m_rem = 0;   // cycles until result; nonzero means busy

    function automatic void calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
                end else if (op == OP_DIV) begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0; m_rem = 0;
        end else begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
            if (m_rem == 0) begin
                if (bus.i_start) begin
                    calc(bus.i_op, bus.i_operand_a, bus.i_operand_b, p_hi, p_lo, p_dz);
                    m_rem = 33;
                end else begin
                    if (bus.i_mthi) m_hi = bus.i_wr_data;
                    if (bus.i_mtlo) m_lo = bus.i_wr_data;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dbz = p_dz;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && run_cmp) begin
            check("cyc_busy", 32'(bus.o_busy), 32'(m_rem != 0));
            check("cyc_done", 32'(bus.o_done), 32'(m_done));
            check("cyc_dbz",  32'(bus.o_div_by_zero), 32'(m_dbz));
            check("cyc_hi",   bus.o_hi, m_hi);
            check("cyc_lo",   bus.o_lo, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    // Callers are positioned at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_start = 1'b1; bus.i_op = op; bus.i_operand_a = a; bus.i_operand_b = b;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_op = 2'($urandom_range(0, 3));
        bus.i_operand_a = $urandom;
        bus.i_operand_b = $urandom;
    endtask

    task automatic wait_done(input string name, output int busy_n);
        logic seen;
        seen = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.o_done) seen = 1'b1;
            else begin
                if (bus.o_busy) busy_n++;
                @(negedge clk);
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    int n, done_cnt;

    initial begin
        bus.i_start = 1'b0; bus.i_op = '0; bus.i_operand_a = '0; bus.i_operand_b = '0;
        bus.i_mthi = 1'b0; bus.i_mtlo = 1'b0; bus.i_wr_data = '0;
        #1 rst = 1'b1;
        #20;
        check("rst_hi", bus.o_hi, 32'h0);
        check("rst_lo", bus.o_lo, 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_dbz", 32'(bus.o_div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_cmp = 1'b1;
        @(negedge clk);

        // MULTU max * max, latency
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu", n);
        check("multu_busy_cycles", 32'(n), 32'd33);
        check("multu_hi", bus.o_hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.o_lo, 32'h0000_0001);
        @(negedge clk);
        check("multu_done_pulse", 32'(bus.o_done), 32'd0);

        // MULT -2*3 then DIV -7/2 back-to-back
        start_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done("mult", n);
        check("mult_hi", bus.o_hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.o_lo, 32'hFFFF_FFFA);
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (10) @(negedge clk);
        check("b2b_hold_hi", bus.o_hi, 32'hFFFF_FFFF);
        check("b2b_hold_lo", bus.o_lo, 32'hFFFF_FFFA);
        wait_done("div", n);
        check("div_busy_cycles", 32'(n), 32'd23);
        check("div_lo", bus.o_lo, 32'hFFFF_FFFD);
        check("div_hi", bus.o_hi, 32'hFFFF_FFFF);
        @(negedge clk);

        // start and MTHI on the same edge: start wins
        bus.i_mthi = 1'b1; bus.i_wr_data = 32'h1234_5678;
        start_op(OP_MULTU, 32'd2, 32'd3);
        bus.i_mthi = 1'b0;
        check("startwin_hi_kept", bus.o_hi, 32'hFFFF_FFFF);
        wait_done("startwin", n);
        check("startwin_hi", bus.o_hi, 32'h0);
        check("startwin_lo", bus.o_lo, 32'h6);
        @(negedge clk);

        // divide by zero, then the overflow case
        start_op(OP_DIVU, 32'h1234_5678, 32'h0);
        wait_done("div0", n);
        check("div0_hi", bus.o_hi, 32'h1234_5678);
        check("div0_lo", bus.o_lo, 32'hFFFF_FFFF);
        check("div0_flag", 32'(bus.o_div_by_zero), 32'd1);
        @(negedge clk);
        check("div0_flag_pulse", 32'(bus.o_div_by_zero), 32'd0);
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divovf", n);
        check("divovf_lo", bus.o_lo, 32'h8000_0000);
        check("divovf_hi", bus.o_hi, 32'h0);
        check("divovf_flag", 32'(bus.o_div_by_zero), 32'd0);
        @(negedge clk);

        // start and MTHI while busy are ignored
        start_op(OP_MULTU, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        bus.i_start = 1'b1; bus.i_op = OP_DIVU; bus.i_operand_a = 32'd100; bus.i_operand_b = 32'd7;
        bus.i_mthi = 1'b1; bus.i_wr_data = 32'hAAAA_AAAA;
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_mthi = 1'b0;
        wait_done("busyign", n);
        check("busyign_hi", bus.o_hi, 32'h0);
        check("busyign_lo", bus.o_lo, 32'h0000_000F);
        @(negedge clk);

        // MTHI+MTLO in idle, then reset mid-divide
        bus.i_mthi = 1'b1; bus.i_mtlo = 1'b1; bus.i_wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.i_mthi = 1'b0; bus.i_mtlo = 1'b0;
        check("mthi_hi", bus.o_hi, 32'hDEAD_BEEF);
        check("mtlo_lo", bus.o_lo, 32'hDEAD_BEEF);
        start_op(OP_DIVU, 32'd9, 32'd2);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_hi", bus.o_hi, 32'h0);
        check("abort_lo", bus.o_lo, 32'h0);
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // recovery after abort
        start_op(OP_DIVU, 32'd9, 32'd2);
        wait_done("recover", n);
        check("recover_lo", bus.o_lo, 32'd4);
        check("recover_hi", bus.o_hi, 32'd1);
        @(negedge clk);
        run_cmp = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
